// File: rtl/ir_sweep_seq.sv
// ir_sweep_seq: IR-array sweep sequencer.
// Turns on the emitters, waits a settle interval, then runs six A2D conversions
// in a fixed channel order and accumulates a signed, weighted line-position error.
// Optional feature macro: LINE_LOST_DET_EN (reading-sum line-lost detection).
module ir_sweep_seq #(
  parameter int unsigned SETTLE_CYC  = 4096,
  parameter int unsigned LOST_THRESH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  output logic        IR_en,
  output logic        busy,
  output logic [15:0] err,
  output logic        err_vld,
  output logic        line_lost
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned CH_W  = 3;
  localparam int unsigned RES_W = 12;
  localparam int unsigned ERR_W = 16;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(5);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CNV    = 2'd2,
    WAIT   = 2'd3
  } state_t;

  // Channel visited at each sweep position.
  function automatic logic [CH_W-1:0] chan_of(input logic [IDX_W-1:0] i);
    logic [CH_W-1:0] c;
    case (i)
      3'd0:    c = 3'd1;
      3'd1:    c = 3'd0;
      3'd2:    c = 3'd4;
      3'd3:    c = 3'd2;
      3'd4:    c = 3'd3;
      default: c = 3'd7;
    endcase
    return c;
  endfunction

  // Weighted contribution of one reading: weights -4,-2,-1,+1,+2,+4 by position.
  function automatic logic [ERR_W-1:0] term_of(input logic [IDX_W-1:0] i,
                                               input logic [RES_W-1:0] r);
    logic [ERR_W-1:0] z;
    logic [ERR_W-1:0] t;
    z = ERR_W'(r);
    case (i)
      3'd0:    t = -(z << 2);
      3'd1:    t = -(z << 1);
      3'd2:    t = -z;
      3'd3:    t = z;
      3'd4:    t = z << 1;
      default: t = z << 2;
    endcase
    return t;
  endfunction

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [ERR_W-1:0] acc, acc_nxt;
  logic [ERR_W-1:0] acc_sum;
  logic [ERR_W-1:0] err_nxt;
  logic [CH_W-1:0]  chnnl_nxt;
  logic             err_vld_nxt;
  logic             strt_nxt;
  logic             busy_nxt;

`ifdef LINE_LOST_DET_EN
  localparam int unsigned SUM_W = 15;
  localparam logic [SUM_W-1:0] LOST_LIM = SUM_W'(LOST_THRESH);

  logic [SUM_W-1:0] sum, sum_nxt;
  logic [SUM_W-1:0] sum_fin;
  logic             lost_nxt;
`else
  logic unused_cfg;
  assign unused_cfg = ^(32'(LOST_THRESH));
  assign line_lost  = 1'b0;
`endif

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    idx_nxt     = idx;
    acc_nxt     = acc;
    err_nxt     = err;
    err_vld_nxt = 1'b0;
    chnnl_nxt   = chnnl;
    acc_sum     = acc + term_of(idx, res);
`ifdef LINE_LOST_DET_EN
    sum_nxt     = sum;
    sum_fin     = sum + SUM_W'(res);
    lost_nxt    = line_lost;
`endif

    case (state)
      IDLE: begin
        if (go) begin
          cnt_nxt   = '0;
          idx_nxt   = '0;
          acc_nxt   = '0;
`ifdef LINE_LOST_DET_EN
          sum_nxt   = '0;
`endif
          state_nxt = SETTLE;
        end
      end

      SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          chnnl_nxt = chan_of(idx);
          state_nxt = CNV;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      // cnv_cmplt is still high from the previous conversion here; ignore it.
      CNV: begin
        state_nxt = WAIT;
      end

      WAIT: begin
        if (cnv_cmplt) begin
          acc_nxt = acc_sum;
`ifdef LINE_LOST_DET_EN
          sum_nxt = sum_fin;
`endif
          if (idx == LAST_IDX) begin
            err_nxt     = acc_sum;
            err_vld_nxt = 1'b1;
`ifdef LINE_LOST_DET_EN
            lost_nxt    = (sum_fin < LOST_LIM);
`endif
            state_nxt   = IDLE;
          end else begin
            idx_nxt   = idx + IDX_W'(1);
            chnnl_nxt = chan_of(idx + IDX_W'(1));
            state_nxt = CNV;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    strt_nxt = (state_nxt == CNV);
    busy_nxt = (state_nxt != IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      acc      <= '0;
      err      <= '0;
      err_vld  <= 1'b0;
      chnnl    <= '0;
      strt_cnv <= 1'b0;
      busy     <= 1'b0;
      IR_en    <= 1'b0;
`ifdef LINE_LOST_DET_EN
      sum       <= '0;
      line_lost <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      idx      <= idx_nxt;
      acc      <= acc_nxt;
      err      <= err_nxt;
      err_vld  <= err_vld_nxt;
      chnnl    <= chnnl_nxt;
      strt_cnv <= strt_nxt;
      busy     <= busy_nxt;
      IR_en    <= busy_nxt;
`ifdef LINE_LOST_DET_EN
      sum       <= sum_nxt;
      line_lost <= lost_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_ir_sweep_seq.sv
// tb_ir_sweep_seq: directed bench for ir_sweep_seq with an A2D responder,
// a sweep-level reference model and a per-cycle output compare.
module tb_ir_sweep_seq;

  localparam int unsigned S  = 8;
  localparam int unsigned LT = 600;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        go = 1'b0;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt = 1'b0;
  logic [11:0] res = 12'd0;
  logic        IR_en;
  logic        busy;
  logic [15:0] err;
  logic        err_vld;
  logic        line_lost;

  ir_sweep_seq #(.SETTLE_CYC(S), .LOST_THRESH(LT)) dut (
    .clk(clk), .rst(rst), .go(go), .strt_cnv(strt_cnv), .chnnl(chnnl),
    .cnv_cmplt(cnv_cmplt), .res(res), .IR_en(IR_en), .busy(busy),
    .err(err), .err_vld(err_vld), .line_lost(line_lost)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;

  // A2D responder state
  int res_tab[8];
  int a2d_delay = 0;
  int pend = 0;
  int cur_res = 0;
  int strt_count = 0;
  int first_strt_cyc = 0;
  int chlog[$];

  // Sweep order and weights
  int ord[6] = '{1, 0, 4, 2, 3, 7};
  int wt[6]  = '{-4, -2, -1, 1, 2, 4};

  // Reference model state
  bit          m_active = 1'b0;
  int          m_left = 0;
  int          m_n = 0;
  bit          m_prev_strt = 1'b0;
  int          reads[6];
  logic        exp_busy = 1'b0;
  logic        exp_strt = 1'b0;
  logic        exp_vld = 1'b0;
  logic        exp_lost = 1'b0;
  logic [2:0]  exp_chnnl = 3'd0;
  logic [15:0] exp_err = 16'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Cycle counter (posedges seen so far)
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference model: what a sweep must look like, driven by sampled inputs
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_active = 0; m_left = 0; m_n = 0;
      exp_busy = 0; exp_strt = 0; exp_vld = 0; exp_lost = 0;
      exp_chnnl = 3'd0; exp_err = 16'd0;
    end else begin
      m_prev_strt = exp_strt;
      exp_strt = 0;
      exp_vld = 0;
      if (!m_active) begin
        if (go) begin
          m_active = 1; m_left = S; m_n = 0;
        end
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          exp_strt = 1; exp_chnnl = 3'(ord[0]);
        end
      end else if (!m_prev_strt && cnv_cmplt) begin
        reads[m_n] = int'(res);
        m_n++;
        if (m_n == 6) begin
          int e, s;
          e = 0; s = 0;
          for (int i = 0; i < 6; i++) begin
            e += wt[i] * reads[i];
            s += reads[i];
          end
          exp_err = e[15:0];
          exp_vld = 1;
`ifdef LINE_LOST_DET_EN
          exp_lost = (s < LT);
`else
          exp_lost = 0;
`endif
          m_active = 0;
        end else begin
          exp_strt = 1; exp_chnnl = 3'(ord[m_n]);
        end
      end
      exp_busy = m_active;
    end
  end

  // Per-cycle compare against the model
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      check("busy", busy, exp_busy);
      check("IR_en", IR_en, exp_busy);
      check("strt_cnv", strt_cnv, exp_strt);
      check("chnnl", chnnl, exp_chnnl);
      check("err", err, exp_err);
      check("err_vld", err_vld, exp_vld);
      check("line_lost", line_lost, exp_lost);
    end
  end

  // A2D responder: cnv_cmplt rises a2d_delay cycles after strt_cnv, stays high until the next start
  initial forever begin
    @(negedge clk);
    if (strt_cnv === 1'b1) begin
      strt_count++;
      chlog.push_back(int'(chnnl));
      if (strt_count == 1) first_strt_cyc = cyc + 1;
      cur_res = res_tab[chnnl];
      if (a2d_delay == 0) begin
        cnv_cmplt = 1'b1; res = 12'(cur_res); pend = 0;
      end else begin
        cnv_cmplt = 1'b0; res = 12'($urandom); pend = a2d_delay;
      end
    end else if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        cnv_cmplt = 1'b1; res = 12'(cur_res);
      end
    end
  end

  task automatic set_tab(input int c1, input int c0, input int c4,
                         input int c2, input int c3, input int c7);
    res_tab[1] = c1; res_tab[0] = c0; res_tab[4] = c4;
    res_tab[2] = c2; res_tab[3] = c3; res_tab[7] = c7;
    res_tab[5] = 12'hABC; res_tab[6] = 12'h555;
  endtask

  task automatic run_sweep(input int dly, input bit poke, output int go_cyc, output int vld_cyc);
    a2d_delay = dly;
    strt_count = 0;
    chlog.delete();
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go_cyc = cyc;
    go = 1'b0;
    vld_cyc = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      go = (poke && (i == 100));
      if (err_vld === 1'b1) begin
        vld_cyc = cyc;
        break;
      end
    end
    go = 1'b0;
    if (vld_cyc < 0) begin
      n_cmp++; n_fail++;
      $display("FAIL sweep_timeout: got no err_vld expected one within 2000 cycles");
    end
  endtask

  initial begin
    int g, v, k;
    int exp_ch[6];
    exp_ch = '{1, 0, 4, 2, 3, 7};
    set_tab(0, 0, 0, 0, 0, 0);

    // Reset and idle
    #1 rst = 1'b1;
    @(negedge clk);
    cmp_en = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_no_strt", strt_count, 0);
    check("idle_IR_en", IR_en, 0);

    // Basic sweep, zero-wait A2D
    set_tab(10, 20, 30, 40, 50, 60);
    run_sweep(0, 0, g, v);
    check("basic_err", err, 32'(16'd270));
    check("first_strt_lat", first_strt_cyc - g, 9);
    check("sweep_len", v - g, S + 12);
    check("basic_nstrt", chlog.size(), 6);
    for (int i = 0; i < 6; i++)
      check("chnnl_order", (i < chlog.size()) ? chlog[i] : -1, exp_ch[i]);
    @(negedge clk);
    check("vld_one_cycle", err_vld, 0);
    check("err_hold", err, 32'(16'd270));

    // Extremes
    set_tab(0, 0, 0, 0, 0, 4095);
    run_sweep(0, 0, g, v);
    check("ext_pos", err, 32'(16'd16380));
    set_tab(4095, 0, 0, 0, 0, 0);
    run_sweep(0, 0, g, v);
    check("ext_neg", err, 32'(16'hC004));

    // Slow handshake with a go poke mid-sweep
    set_tab(100, 200, 300, 400, 500, 600);
    run_sweep(40, 1, g, v);
    check("hs_nstrt", strt_count, 6);
    check("hs_err", err, 32'(16'd2700));
    repeat (5) @(negedge clk);
    check("hs_no_restart", busy, 0);

    // Reset during the third WAIT
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    a2d_delay = 40;
    strt_count = 0;
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    k = 0;
    while (strt_count < 3 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("rst3_reached", (strt_count >= 3) ? 1 : 0, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_IR_en", IR_en, 0);
    check("rst_mid_err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check("rst_stale_ignored", busy, 0);
    check("rst_stale_err", err, 0);
    set_tab(10, 20, 30, 40, 50, 60);
    run_sweep(3, 0, g, v);
    check("post_rst_err", err, 32'(16'd270));

    // Line-lost
    set_tab(50, 50, 50, 50, 50, 50);
    run_sweep(0, 0, g, v);
    check("ll_err", err, 0);
`ifdef LINE_LOST_DET_EN
    check("ll_low", line_lost, 1);
`else
    check("ll_low", line_lost, 0);
`endif
    set_tab(200, 200, 200, 200, 200, 200);
    run_sweep(0, 0, g, v);
    check("ll_high", line_lost, 0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ir_sweep_seq.md
# ir_sweep_seq

Sensor-sweep sequencer for the line follower's IR array. On each `go`, it enables the IR emitters and waits a settle interval. It then drives the A2D SPI interface through six channel conversions in a fixed order and accumulates a weighted signed line-position error. It sits directly upstream of the A2D interface, driving `strt_cnv`/`chnnl` and consuming `cnv_cmplt`/`res`, and feeds the steering controller.

## Interface
- `SETTLE_CYC`, default 4096: clk cycles the emitters are on before the first conversion; legal range 1..65535.
- `LOST_THRESH`, default 1024: unsigned 15-bit threshold on the reading sum for line-lost detection; used only with `LINE_LOST_DET_EN`.

- `clk`, input, 1: system clock; all state changes on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `go`, input, 1: start-sweep request; sampled only in IDLE.
- `strt_cnv`, output, 1: one-cycle conversion start to the A2D interface.
- `chnnl`, output, 3: A2D channel select; held stable from `strt_cnv` until the matching `cnv_cmplt`.
- `cnv_cmplt`, input, 1: A2D conversion done; a level that stays high until the next `strt_cnv`.
- `res`, input, 12: A2D result (unsigned), valid while `cnv_cmplt` is high.
- `IR_en`, output, 1: IR emitter enable.
- `busy`, output, 1: high in every state except IDLE.
- `err`, output, 16: signed weighted error of the last completed sweep.
- `err_vld`, output, 1: one-cycle pulse when `err` updates.
- `line_lost`, output, 1: set when the sweep reading sum is below `LOST_THRESH`.

## Operation
- States: IDLE, SETTLE, CNV, WAIT.
- IDLE:
  - On `go`=1: clear the settle counter, channel index `idx`, and accumulator; go to SETTLE.
  - Otherwise stay in IDLE.
- SETTLE:
  - `IR_en`=1 while in this state; the counter increments each cycle.
  - When counter == `SETTLE_CYC`-1, go to CNV.
- CNV:
  - Lasts exactly one cycle with `strt_cnv`=1 and `chnnl`=order[`idx`]; then go to WAIT.
- WAIT:
  - `cnv_cmplt` is sampled only here. In the CNV cycle, `cnv_cmplt` is stale from the prior conversion and is ignored.
  - On `cnv_cmplt`=1: acc += w[`idx`]·`res`.
  - If `idx`==5: go to IDLE, load `err` with the final sum, pulse `err_vld`, and drop `IR_en`.
  - Otherwise: `idx`++ and go to CNV.
- Channel order by `idx` 0..5: 1, 0, 4, 2, 3, 7.
- Weights by `idx` 0..5: −4, −2, −1, +1, +2, +4.
- Arithmetic:
  - `res` is zero-extended and weighted by shift/negate; the accumulator is 16-bit two's complement.
  - The maximum magnitude is 7·4095 = 28665, so no overflow handling is required.
- `IR_en` is 1 in SETTLE, CNV, and WAIT, and 0 in IDLE.
- `go` while `busy` is ignored; no queuing.
- `err` holds its value between sweeps. It changes only on the cycle `err_vld` pulses.

## Timing
- Reset values: `strt_cnv`=0, `chnnl`=0, `IR_en`=0, `busy`=0, `err`=0, `err_vld`=0, `line_lost`=0, state=IDLE.
- Asserting `rst` in any state aborts the sweep immediately:
  - Outputs return to their reset values asynchronously.
  - A conversion in flight is abandoned and its later `cnv_cmplt` is ignored (the FSM is in IDLE).
- Sequence from a `go` sampled at edge T:
  - `busy` and `IR_en` are high from T+1.
  - The first `strt_cnv` is at cycle T+1+`SETTLE_CYC`, with `chnnl`=1.
  - Each conversion costs 1 CNV cycle plus the WAIT cycles until `cnv_cmplt` is seen.
  - `err`/`err_vld`/`line_lost` update on the edge after the 6th `cnv_cmplt` is observed; `busy`/`IR_en` fall on that same edge.
- With zero-wait A2D (`cnv_cmplt` high in the first WAIT cycle), the sweep takes `SETTLE_CYC` + 12 cycles from the `go` edge to `err_vld`.
- A new `go` may be accepted on the cycle after `err_vld`.

## Configuration
- `LINE_LOST_DET_EN` defined:
  - A 15-bit unsigned sum of all six `res` values is accumulated alongside `err`.
  - `line_lost` is registered with `err_vld` as (sum < `LOST_THRESH`) and held until the next sweep completes.
- `LINE_LOST_DET_EN` undefined:
  - No sum logic is built; `line_lost` is tied to 0; `LOST_THRESH` is unused.

## Test plan
- Reset/idle: `rst` pulse, `SETTLE_CYC`=8, no `go` -> all outputs 0 indefinitely, `strt_cnv` never asserted.
- Basic sweep: `SETTLE_CYC`=8, A2D model returns `res`=10,20,30,40,50,60 in conversion order -> `chnnl` sequence 1,0,4,2,3,7, first `strt_cnv` 9 cycles after the `go` edge, `err`=270 with a one-cycle `err_vld`.
- Extremes:
  - `res`=0 for channels 1,0,4,2,3 and 4095 for channel 7 -> `err`=16380.
  - Mirror case (4095 only on channel 1) -> `err`=−16380 (0xC004).
- Handshake: model asserts `cnv_cmplt` 40 cycles after each `strt_cnv` and leaves it high until the next start; also pulse `go` mid-sweep -> exactly 6 `strt_cnv` pulses, no duplicate accumulation, `go` ignored, `busy` high throughout.
- Reset mid-sweep: assert `rst` during the 3rd WAIT -> `IR_en`/`busy` drop immediately, `err` stays 0, next `go` runs a clean sweep with a correct result.
- Line-lost: `LOST_THRESH`=600, all `res`=50 (sum 300) -> `line_lost`=1 with `LINE_LOST_DET_EN`, 0 without; then all `res`=200 (sum 1200) -> `line_lost`=0.
